// File: rtl/greater_scan_ctrl_pkg.sv
// Shared definitions for the greater_scan_ctrl burst-maximum sequencer.
package greater_scan_ctrl_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SCAN = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

endpackage

// File: rtl/greater_scan_ctrl_cmp.sv
// Unsigned magnitude comparator: f is high when a is strictly greater than b.
module greater_cmp #(
  parameter int WIDTH = 2
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             f
);

  assign f = (a > b);

endmodule

// File: rtl/greater_scan_ctrl.sv
// Streams a burst of len values and reports the maximum and its first index,
// reusing a single comparator against the running maximum register.
module greater_scan_ctrl
  import greater_scan_ctrl_pkg::*;
#(
  parameter int WIDTH = 2,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             busy,
  output logic             done,
  output logic             empty,
  output logic [WIDTH-1:0] max_val,
  output logic [CNT_W-1:0] max_idx,
  output logic [1:0]       fsm_state
);

  // Handshake: a beat transfers on a rising clk edge where in_valid and
  // in_ready are both high; in_data is only looked at on such an edge.

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] len_q;
  logic             gt;
  logic             beat;
  logic             last_beat;

  greater_cmp #(.WIDTH(WIDTH)) u_cmp (
    .a (in_data),
    .b (max_val),
    .f (gt)
  );

  assign beat      = in_valid & in_ready;
  assign last_beat = (cnt == len_q - CNT_W'(1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      len_q   <= '0;
      empty   <= 1'b0;
      max_val <= '0;
      max_idx <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            len_q <= len;
            cnt   <= '0;
            empty <= (len == '0);
            state <= (len == '0) ? DONE : SCAN;
          end
        end
        SCAN: begin
          if (beat) begin
            // First beat seeds the maximum; later beats replace it only on a
            // strict increase so ties keep the earliest index.
            if (cnt == '0) begin
              max_val <= in_data;
              max_idx <= '0;
            end else if (gt) begin
              max_val <= in_data;
              max_idx <= cnt;
            end
            cnt <= cnt + CNT_W'(1);
            if (last_beat) state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == SCAN);
  assign busy      = (state == SCAN) || (state == DONE);
  assign done      = (state == DONE);
  assign fsm_state = state;

endmodule

// File: doc/greater_scan_ctrl.md
Name: greater_scan_ctrl

Overview:
Sequencer that shares one WIDTH-bit magnitude comparator (`greater_cmp`) across a burst of input values. It accepts a burst of len values over a valid/ready handshake and compares each against the running maximum. At the end it reports the maximum value and the index of its first occurrence. It sits between a streaming source and downstream logic that needs the largest element of a burst.

Parameters:
WIDTH, 2, bit width of each data value and of the comparator operands
CNT_W, 4, width of the length and index fields; max burst length 2**CNT_W - 1

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk
start  input  1  begin a new burst; sampled only in IDLE
len  input  CNT_W  number of elements in the burst; captured when start is accepted
in_valid  input  1  source has a value on in_data
in_data  input  WIDTH  element value
in_ready  output  1  block accepts in_data this cycle; high only in SCAN
busy  output  1  high in SCAN and DONE
done  output  1  one-cycle pulse marking results valid
empty  output  1  burst had len=0; valid with done, held until next start
max_val  output  WIDTH  largest element of last burst
max_idx  output  CNT_W  index (0-based) of first occurrence of max_val

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE. in_ready, busy, done, empty, max_val and max_idx are all 0. The element counter is 0. Reset overrides everything, including a burst in progress; no done pulse is produced for an aborted burst.
- States:
  - IDLE: start=1 captures len, clears the element counter and empty, and goes to SCAN. If len=0 it goes to DONE instead and sets empty=1.
  - SCAN: in_ready=1. A handshake is in_valid & in_ready.
  - DONE: lasts exactly one cycle with done=1, then returns to IDLE.
- start outside IDLE is ignored, including start in the DONE cycle. len is only sampled at start acceptance.
- Handshake in SCAN, on each accepted beat with counter value k:
  - k=0: max_val<=in_data, max_idx<=0.
  - k>0: if `greater_cmp`(in_data, max_val)=1, i.e. strictly greater, then max_val<=in_data and max_idx<=k. Otherwise hold. Ties keep the earlier index.
  - Counter increments by 1. When the accepted beat is number len (k=len-1), the next state is DONE.
- Cycles with in_valid=0 in SCAN stall with no state change. There is no timeout.
- Latency: done rises on the clk edge following the last accepted beat. For len=0, done rises 1 cycle after start is accepted.
- max_val, max_idx and empty are registered outputs. They update only as stated above and hold their values through IDLE until the next accepted start. At the next start, empty clears; max_val and max_idx change only when the first beat is accepted.
- Comparator: purely combinational, unsigned. F=1 iff A>B. Operands are in_data and the max_val register.
- Width rules: the counter is CNT_W bits. len=2**CNT_W-1 completes without wrap. max_idx never exceeds len-1.

Decomposition:
- Shared package: the state encodings IDLE=2'd0, SCAN=2'd1 and DONE=2'd2.
- One sub-module, `greater_cmp` #(WIDTH): inputs A and B, output F, combinational unsigned A>B. The controller instantiates it once.

Test Plan (WIDTH=2, CNT_W=4):
- Basic burst: start with len=4, data 1,3,2,0 streamed with in_valid held high -> done pulse 1 cycle after the 4th beat; max_val=3, max_idx=1, empty=0; busy low the cycle after done.
- Ties and stalls: len=3, data 2,2,1, with in_valid deasserted for 2 cycles between beats -> in_ready stays 1 during stalls; max_val=2, max_idx=0; done only after the 3rd beat.
- Empty burst: start with len=0 -> done=1 and empty=1 on the next cycle; max_val and max_idx retain their previous values; back in IDLE the cycle after.
- Ignored start: start pulsed with len=1 during SCAN of a len=2 burst with data 0,3 -> burst completes after 2 beats with max_val=3, max_idx=1; no extra done pulse.
- Reset mid-scan: rst_n low for 1 cycle after the 2nd beat of a len=5 burst -> next cycle all outputs 0 and state IDLE, no done pulse. A new start with len=1 and data 3 then gives max_val=3, max_idx=0.
- Full length: len=15, data 0 except 3 at index 14 -> max_idx=14, max_val=3; counter does not wrap.
